dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 cmd_valid  in  1  CPU start pulse; sampled only in IDLE.
REQ-004 cmd_addr  in  16  memory word address of the first destination word.
REQ-005 cmd_blocks  in  2  number of 4-word blocks to move (0..3).
REQ-006 offset  out  2  device storage index presented to the external device.
REQ-007 dev_data  in  64  device block data for the current offset, combinational from device.
REQ-008 br  out  1  bus request to CPU.
REQ-009 bg  in  1  bus grant from CPU.
REQ-010 mem_addr  out  16  memory write address.
REQ-011 mem_data  out  64  memory write data (4 words).
REQ-012 mem_write  out  1  memory write strobe, held until mem_ready.
REQ-013 mem_ready  in  1  memory write-complete, one cycle.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 dma_done  out  1  one-cycle completion interrupt to CPU.

Function
REQ-016 States SHALL be IDLE, REQ, WRITE, DONE.
REQ-017 IDLE: cmd_valid with cmd_blocks>0 SHALL latch cmd_addr, cmd_blocks, clear block index k, go to REQ; br high next cycle.
REQ-018 IDLE: cmd_valid with cmd_blocks==0 SHALL go to DONE without asserting br.
REQ-019 REQ: br held high; bg high SHALL go to WRITE next cycle.
REQ-020 WRITE: offset=k, mem_addr=base+4*k (16-bit wrap), mem_data=dev_data registered on WRITE entry, mem_write high.
REQ-021 WRITE with mem_ready high: k+1; if k+1==blocks SHALL go to DONE, else stay WRITE for next block (no idle cycle).
REQ-022 WRITE with bg low (grant revoked): mem_write low next cycle, return to REQ, retry same block k.
REQ-023 mem_ready and bg-low in the same cycle: the write SHALL count as complete; bg-low takes effect on next block.
REQ-024 DONE: br low, dma_done high exactly one cycle, then IDLE.
REQ-025 cmd_valid while busy SHALL be ignored (no queueing).
REQ-026 mem_write SHALL never be high while bg is low for more than one cycle.
REQ-027 offset SHALL be 0 outside WRITE.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, k=0, br=0, mem_write=0, dma_done=0, busy=0, offset=0, mem_addr=0, mem_data=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no dma_done.

Configuration
REQ-030 DMA_CYCLE_STEAL_EN defined: after each non-final block completes, br SHALL drop for exactly one cycle and FSM re-enters REQ for block k+1.
REQ-031 DMA_CYCLE_STEAL_EN undefined: burst mode; br held continuously from REQ entry until DONE.

Structure
REQ-032 Shared package dma_pkg SHALL hold WORD_SIZE=16, BLOCK_WORDS=4, DEVICE_BIT_LEN=2, state encoding typedef.
REQ-033 One sub-module dma_addr_gen SHALL hold base address, block counter k, and compute mem_addr/offset/last flag.

Verification
REQ-034 cmd_addr=0x01F4, blocks=3, bg one cycle after br, mem_ready 2 cycles after each write -> writes at 0x1F4/0x1F8/0x1FC with offsets 0/1/2, data equals device storage, one dma_done.
REQ-035 blocks=0 -> br never high, dma_done pulse two cycles after cmd_valid.
REQ-036 bg dropped during block 1 write, restored 5 cycles later -> block 1 rewritten at base+4, total three completed writes, one dma_done.
REQ-037 reset_n low during block 2 -> br, mem_write drop immediately, no dma_done; new cmd afterwards completes normally.
REQ-038 cmd_addr=0xFFFC, blocks=2 -> second write at 0x0000.
REQ-039 DMA_CYCLE_STEAL_EN defined, blocks=3 -> br low for one cycle between each block; undefined -> br continuous.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the block DMA engine: word/block geometry,
// FSM state encoding and the block address helper.
package dma_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int BLOCK_WORDS    = 4;
  localparam int DEVICE_BIT_LEN = 2;
  localparam int DATA_W         = WORD_SIZE * BLOCK_WORDS;
  localparam int BLOCK_SHIFT    = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } dma_state_e;

  // Memory word address of block k: base + BLOCK_WORDS*k, wrapping at 16 bits.
  function automatic logic [WORD_SIZE-1:0] block_addr(
    input logic [WORD_SIZE-1:0]      base,
    input logic [DEVICE_BIT_LEN-1:0] k
  );
    return base + {{(WORD_SIZE-DEVICE_BIT_LEN-BLOCK_SHIFT){1'b0}}, k, {BLOCK_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Address generator: holds the latched base address, block count and the
// current block index k; derives the device offset, memory address and
// the "this is the final block" flag.
module dma_addr_gen
  import dma_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic                      i_adv,
  input  logic                      i_in_write,
  input  logic [WORD_SIZE-1:0]      i_base,
  input  logic [DEVICE_BIT_LEN-1:0] i_blocks,
  output logic [DEVICE_BIT_LEN-1:0] o_offset,
  output logic [WORD_SIZE-1:0]      o_mem_addr,
  output logic                      o_last
);

  logic [WORD_SIZE-1:0]      r_base;
  logic [DEVICE_BIT_LEN-1:0] r_blocks;
  logic [DEVICE_BIT_LEN-1:0] r_k;

  // Latch a new command (k restarts at 0) or step k when a block completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base   <= {WORD_SIZE{1'b0}};
      r_blocks <= {DEVICE_BIT_LEN{1'b0}};
      r_k      <= {DEVICE_BIT_LEN{1'b0}};
    end else if (i_load) begin
      r_base   <= i_base;
      r_blocks <= i_blocks;
      r_k      <= {DEVICE_BIT_LEN{1'b0}};
    end else if (i_adv) begin
      r_k      <= r_k + {{(DEVICE_BIT_LEN-1){1'b0}}, 1'b1};
    end else begin
      r_k      <= r_k;
    end
  end

  // The device only sees a non-zero index while a block is being written.
  assign o_offset   = i_in_write ? r_k : {DEVICE_BIT_LEN{1'b0}};
  assign o_mem_addr = block_addr(r_base, r_k);
  // One extra bit so k+1 cannot wrap onto the block count.
  assign o_last     = (({1'b0, r_k} + {{DEVICE_BIT_LEN{1'b0}}, 1'b1}) == {1'b0, r_blocks});

endmodule

// File: rtl/dma_engine.sv
// Block DMA engine: moves 1..3 four-word blocks from an external device into
// memory after winning the bus from the CPU.
// Build option DMA_CYCLE_STEAL_EN: when defined, the bus request is released
// for one cycle between blocks; otherwise the bus is held for the whole burst.
module dma_engine
  import dma_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  input  logic [WORD_SIZE-1:0]      cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0] cmd_blocks,
  output logic [DEVICE_BIT_LEN-1:0] offset,
  input  logic [DATA_W-1:0]         dev_data,
  output logic                      br,
  input  logic                      bg,
  output logic [WORD_SIZE-1:0]      mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_write,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      dma_done
);

  dma_state_e r_state;
  dma_state_e w_state_nxt;
  logic       r_steal;
  logic       w_steal_nxt;
  logic       w_load;
  logic       w_adv;
  logic       w_last;
  logic       w_in_write;
  logic       r_br;
  logic       r_busy;
  logic       r_mem_write;
  logic       r_dma_done;
  logic       w_br_nxt;
  logic       w_busy_nxt;
  logic       w_wr_nxt;

  assign w_in_write = (r_state == ST_WRITE);

  dma_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_load),
    .i_adv      (w_adv),
    .i_in_write (w_in_write),
    .i_base     (cmd_addr),
    .i_blocks   (cmd_blocks),
    .o_offset   (offset),
    .o_mem_addr (mem_addr),
    .o_last     (w_last)
  );

  // Next-state decode; r_steal marks the one released-bus cycle after a block.
  always_comb begin
    w_state_nxt = r_state;
    w_steal_nxt = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_blocks != {DEVICE_BIT_LEN{1'b0}}) begin
            w_load      = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (r_steal) begin
          w_state_nxt = ST_REQ;
        end else if (bg) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          // A completed write always counts, even if the grant is pulled now.
          w_adv = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            w_state_nxt = ST_REQ;
            w_steal_nxt = 1'b1;
`else
            if (bg) begin
              w_state_nxt = ST_WRITE;
            end else begin
              w_state_nxt = ST_REQ;
            end
`endif
          end
        end else if (!bg) begin
          // Grant revoked mid-write: back off and retry the same block.
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    w_br_nxt   = 1'b0;
    w_busy_nxt = 1'b0;
    w_wr_nxt   = 1'b0;
    if (w_state_nxt == ST_WRITE) begin
      w_br_nxt = 1'b1;
      w_wr_nxt = 1'b1;
    end else if (w_state_nxt == ST_REQ) begin
      w_br_nxt = !w_steal_nxt;
    end else begin
      w_br_nxt = 1'b0;
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_steal     <= 1'b0;
      r_br        <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_write <= 1'b0;
      r_dma_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_steal     <= w_steal_nxt;
      r_br        <= w_br_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_write <= w_wr_nxt;
      r_dma_done  <= (r_state == ST_DONE);
    end
  end

  assign br        = r_br;
  assign busy      = r_busy;
  assign mem_write = r_mem_write;
  assign dma_done  = r_dma_done;
  // Device data is combinational on offset, which is held at k for the whole
  // block, so the write word is stable from WRITE entry until mem_ready.
  assign mem_data  = w_in_write ? dev_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: table of transfers plus hand sequences.
module tb_dma_engine;
  import dma_pkg::*;

`ifdef DMA_CYCLE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [1:0]  cmd_blocks = 2'd0;
  logic [1:0]  offset;
  logic [63:0] dev_data;
  logic        br, bg;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_write, mem_ready, busy, dma_done;

  always #5 clk = ~clk;

  dma_engine dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_blocks(cmd_blocks), .offset(offset), .dev_data(dev_data), .br(br),
    .bg(bg), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_ready(mem_ready), .busy(busy), .dma_done(dma_done)
  );

  // Device storage, read combinationally by offset.
  logic [63:0] storage [4];
  assign dev_data = storage[offset];

  // CPU / memory models (auto) or manual drive from the test sequence.
  bit   auto_en = 1'b1;
  logic auto_bg = 1'b0, auto_ready = 1'b0, man_bg = 1'b0, man_ready = 1'b0;
  assign bg        = auto_en ? auto_bg : man_bg;
  assign mem_ready = auto_en ? auto_ready : man_ready;

  int drop_block = -1;
  int drop_left = 0;
  bit drop_done = 1'b0;
  int lat = 2;
  int rcnt = 0;

  always @(negedge clk) begin
    if (!reset_n) auto_bg = 1'b0;
    else if (drop_left > 0) begin auto_bg = 1'b0; drop_left--; end
    else if (drop_block >= 0 && !drop_done && mem_write && offset == drop_block[1:0]) begin
      auto_bg = 1'b0; drop_left = 4; drop_done = 1'b1;
    end
    else auto_bg = br;
  end

  always @(negedge clk) begin
    if (!reset_n || !mem_write) begin auto_ready = 1'b0; rcnt = 0; end
    else if (auto_ready) begin auto_ready = 1'b0; rcnt = 0; end
    else if (rcnt >= lat) auto_ready = 1'b1;
    else rcnt++;
  end

  // Scoreboard log of completed writes, done pulses, br rises, bus-rule breaks.
  logic [15:0] log_addr[$];
  logic [63:0] log_data[$];
  logic [1:0]  log_off[$];
  int done_cnt = 0, br_rises = 0, viol_cnt = 0, wbg_run = 0;
  logic br_prev = 1'b0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (mem_write && mem_ready) begin
        log_addr.push_back(mem_addr); log_data.push_back(mem_data); log_off.push_back(offset);
      end
      if (dma_done) done_cnt++;
      if (br && !br_prev) br_rises++;
      if (mem_write && !bg) begin wbg_run++; if (wbg_run > 1) viol_cnt++; end
      else wbg_run = 0;
    end
    br_prev = br;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_off.delete();
    done_cnt = 0; br_rises = 0;
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [1:0] b);
    @(negedge clk);
    cmd_addr = a; cmd_blocks = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dma_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_write(input logic [1:0] off, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_write && offset == off) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [15:0]      addr;
    logic [1:0]       blocks;
    int               drop_blk;
    int               exp_writes;
    logic [2:0][15:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit ok;
    int exp_rises;

    vecs[0] = '{16'h01F4, 2'd3, -1, 3, {16'h01FC, 16'h01F8, 16'h01F4}};
    vecs[1] = '{16'hFFFC, 2'd2, -1, 2, {16'h0000, 16'h0000, 16'hFFFC}};
    vecs[2] = '{16'h0100, 2'd1, -1, 1, {16'h0000, 16'h0000, 16'h0100}};
    vecs[3] = '{16'h0040, 2'd0, -1, 0, {16'h0000, 16'h0000, 16'h0000}};
    vecs[4] = '{16'h01F4, 2'd3,  1, 3, {16'h01FC, 16'h01F8, 16'h01F4}};
    vecs[5] = '{16'hABCE, 2'd3,  2, 3, {16'hABD6, 16'hABD2, 16'hABCE}};
    vecs[6] = '{16'hFFF8, 2'd3, -1, 3, {16'h0000, 16'hFFFC, 16'hFFF8}};

    for (int j = 0; j < 4; j++) storage[j] = 64'h0123_4567_89AB_CDEF ^ {32'(j), 32'(j * 7 + 1)};

    // Reset state
    #1;
    check("rst_br", br, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", dma_done, 1'b0);
    check("rst_offset", offset, 2'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_data", mem_data, 64'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transfers
    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 4; j++) storage[j] = 64'hF00D_0000_0000_0000 ^ {32'(v), 32'(j * 257 + 3)};
      drop_block = vecs[v].drop_blk; drop_done = 1'b0;
      clear_logs();
      send_cmd(vecs[v].addr, vecs[v].blocks);
      wait_done(400, ok);
      check($sformatf("v%0d_done_seen", v), ok, 1'b1);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_writes", v), log_addr.size(), vecs[v].exp_writes);
      for (int i = 0; i < vecs[v].exp_writes && i < log_addr.size(); i++) begin
        check($sformatf("v%0d_w%0d_addr", v, i), log_addr[i], vecs[v].exp_addr[i]);
        check($sformatf("v%0d_w%0d_data", v, i), log_data[i], storage[i]);
        check($sformatf("v%0d_w%0d_off", v, i), log_off[i], i);
      end
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      exp_rises = STEAL ? int'(vecs[v].blocks) : ((vecs[v].blocks != 2'd0) ? 1 : 0);
      check($sformatf("v%0d_br_rises", v), br_rises, exp_rises);
      check($sformatf("v%0d_idle_busy", v), busy, 1'b0);
    end
    drop_block = -1;

    // Zero-block command: no br, dma_done two cycles after cmd_valid
    clear_logs();
    @(negedge clk);
    cmd_addr = 16'h1234; cmd_blocks = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("zb_c1_done", dma_done, 1'b0);
    check("zb_c1_busy", busy, 1'b1);
    check("zb_c1_br", br, 1'b0);
    @(negedge clk);
    check("zb_c2_done", dma_done, 1'b1);
    check("zb_c2_busy", busy, 1'b0);
    @(negedge clk);
    check("zb_c3_done", dma_done, 1'b0);
    check("zb_br_rises", br_rises, 0);

    // Command while busy is dropped, not queued
    clear_logs();
    send_cmd(16'h0800, 2'd2);
    @(negedge clk);
    cmd_addr = 16'h5000; cmd_blocks = 2'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(200, ok);
    check("ign_done_seen", ok, 1'b1);
    repeat (10) @(negedge clk);
    check("ign_writes", log_addr.size(), 2);
    if (log_addr.size() >= 2) check("ign_w1_addr", log_addr[1], 16'h0804);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_idle", busy, 1'b0);

    // mem_ready and grant loss in the same cycle
    auto_en = 1'b0; man_bg = 1'b0; man_ready = 1'b0;
    clear_logs();
    send_cmd(16'h0400, 2'd2);
    check("mr_req_br", br, 1'b1);
    man_bg = 1'b1;
    @(negedge clk);
    check("mr_w0_write", mem_write, 1'b1);
    check("mr_w0_addr", mem_addr, 16'h0400);
    man_ready = 1'b1; man_bg = 1'b0;
    @(negedge clk);
    man_ready = 1'b0;
    check("mr_after_write", mem_write, 1'b0);
    check("mr_after_count", log_addr.size(), 1);
    check("mr_after_busy", busy, 1'b1);
    check("mr_after_br", br, !STEAL);
    man_bg = 1'b1;
    wait_write(2'd1, 10, ok);
    check("mr_w1_seen", ok, 1'b1);
    check("mr_w1_addr", mem_addr, 16'h0404);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    wait_done(10, ok);
    check("mr_done_seen", ok, 1'b1);
    check("mr_writes", log_addr.size(), 2);
    man_bg = 1'b0;
    auto_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during block 2 abandons the transfer; the next one completes
    clear_logs();
    send_cmd(16'h0200, 2'd3);
    wait_write(2'd2, 200, ok);
    check("rm_blk2_seen", ok, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rm_br", br, 1'b0);
    check("rm_mem_write", mem_write, 1'b0);
    check("rm_busy", busy, 1'b0);
    check("rm_offset", offset, 2'd0);
    check("rm_mem_addr", mem_addr, 16'h0000);
    check("rm_mem_data", mem_data, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rm_no_done", done_cnt, 0);
    check("rm_writes", log_addr.size(), 2);
    clear_logs();
    send_cmd(16'h0300, 2'd1);
    wait_done(200, ok);
    check("rm_new_done_seen", ok, 1'b1);
    repeat (3) @(negedge clk);
    check("rm_new_writes", log_addr.size(), 1);
    if (log_addr.size() >= 1) check("rm_new_addr", log_addr[0], 16'h0300);
    check("rm_new_done_cnt", done_cnt, 1);

    check("bus_rule_violations", viol_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
